scalar_sched: RTL and testbench

Time-multiplexes one shared `scalar` gain unit across `NUM_CH` MIDI voice channels. Each channel has its own gain (`scalar`, `shift`). On every audio sample tick the block snapshots all channel operands and issues them to the unit one per cycle. It then sums the returned products into one mixed sample for the DAC/output path, so the design needs a single multiplier instead of one per voice.

---
 rtl/scalar_sched.sv | 146 ++++++++++++++
 tb/tb_scalar_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_sched.sv
// Shares one scalar gain unit across NUM_CH voices, issuing one channel per cycle and mixing the results.
// Optional build macro SCALAR_SCHED_SAT_EN: saturate mix_out instead of wrapping.
module scalar_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int SCALAR_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH*DATA_W-1:0] ch_scalar,
    input  logic [NUM_CH*5-1:0]      ch_shift,
    output logic [DATA_W-1:0]        sc_data_in,
    output logic [DATA_W-1:0]        sc_scalar,
    output logic [4:0]               sc_shift,
    input  logic [DATA_W-1:0]        sc_data_out,
    output logic [DATA_W-1:0]        mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int ACC_W = DATA_W + $clog2(NUM_CH) + 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    nidx;
    logic                snap_en     [NUM_CH];
    logic [DATA_W-1:0]   snap_data   [NUM_CH];
    logic [DATA_W-1:0]   snap_scalar [NUM_CH];
    logic [4:0]          snap_shift  [NUM_CH];
    logic                sc_valid;
    logic [SCALAR_LAT-1:0] tag;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [DATA_W-1:0]   mix_next;
    logic                tags_behind;
    logic                last_consume;

    // sc_valid marks operands currently on the bus; the tag chain then tracks them until the result returns
    always_comb begin
        nidx        = idx + 1'b1;
        acc_sum     = acc + {{(ACC_W-DATA_W){1'b0}}, sc_data_out};
        tags_behind = sc_valid;
        for (int j = 0; j < SCALAR_LAT - 1; j++) begin
            tags_behind = tags_behind | tag[j];
        end
        last_consume = (state == DRAIN) && tag[SCALAR_LAT-1] && !tags_behind;
        mix_next     = acc_sum[DATA_W-1:0];
`ifdef SCALAR_SCHED_SAT_EN
        if (|acc_sum[ACC_W-1:DATA_W]) begin
            mix_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            sc_valid   <= 1'b0;
            tag        <= '0;
            acc        <= '0;
            sc_data_in <= '0;
            sc_scalar  <= '0;
            sc_shift   <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_en[i]     <= 1'b0;
                snap_data[i]   <= '0;
                snap_scalar[i] <= '0;
                snap_shift[i]  <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            tag[0]    <= sc_valid;
            for (int j = 1; j < SCALAR_LAT; j++) begin
                tag[j] <= tag[j-1];
            end
            if (tag[SCALAR_LAT-1]) begin
                acc <= acc_sum;
            end
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_en[i]     <= ch_en[i];
                            snap_data[i]   <= ch_data[i*DATA_W +: DATA_W];
                            snap_scalar[i] <= ch_scalar[i*DATA_W +: DATA_W];
                            snap_shift[i]  <= ch_shift[i*5 +: 5];
                        end
                        // Channel 0 goes straight from the inputs so it is on the bus the cycle after the tick
                        sc_data_in <= ch_en[0] ? ch_data[DATA_W-1:0]   : '0;
                        sc_scalar  <= ch_en[0] ? ch_scalar[DATA_W-1:0] : '0;
                        sc_shift   <= ch_en[0] ? ch_shift[4:0]         : '0;
                        sc_valid   <= 1'b1;
                        acc        <= '0;
                        idx        <= '0;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (idx == IDX_W'(NUM_CH - 1)) begin
                        sc_data_in <= '0;
                        sc_scalar  <= '0;
                        sc_shift   <= '0;
                        sc_valid   <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        sc_data_in <= snap_en[nidx] ? snap_data[nidx]   : '0;
                        sc_scalar  <= snap_en[nidx] ? snap_scalar[nidx] : '0;
                        sc_shift   <= snap_en[nidx] ? snap_shift[nidx]  : '0;
                        idx        <= nidx;
                    end
                end
                DRAIN: begin
                    // The final product is folded into mix_out on the same edge it is consumed
                    if (last_consume) begin
                        mix_out   <= mix_next;
                        mix_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_sched.sv
// Bench for scalar_sched: frame-level reference model plus directed scenarios and randomized ticks/resets.
module tb_scalar_sched;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int LAT    = 2;
    localparam int FRAME  = NUM_CH + LAT + 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     sample_tick = 1'b0;
    logic [NUM_CH-1:0]        ch_en = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH*DATA_W-1:0] ch_scalar = '0;
    logic [NUM_CH*5-1:0]      ch_shift = '0;
    logic [DATA_W-1:0]        sc_data_in, sc_scalar, sc_data_out, mix_out;
    logic [4:0]               sc_shift;
    logic                     mix_valid, busy, overrun;

    int vectors = 0;
    int miscompares = 0;

    scalar_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCALAR_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .ch_en(ch_en), .ch_data(ch_data), .ch_scalar(ch_scalar), .ch_shift(ch_shift),
        .sc_data_in(sc_data_in), .sc_scalar(sc_scalar), .sc_shift(sc_shift),
        .sc_data_out(sc_data_out), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] scaleOf(input logic [15:0] d, input logic [15:0] s, input logic [4:0] sh);
        logic [31:0] p;
        p = {16'd0, d} * {16'd0, s};
        p = p >> sh;
        return p[15:0];
    endfunction

    // Shared gain unit with a two-cycle latency
    logic [15:0] pipe1 = '0, pipe2 = '0;
    assign sc_data_out = pipe2;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe1 <= '0;
            pipe2 <= '0;
        end else begin
            pipe1 <= scaleOf(sc_data_in, sc_scalar, sc_shift);
            pipe2 <= pipe1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: age counts cycles since the accepted tick, 0 means idle
    int          age = 0;
    logic [15:0] mixExp = '0;
    logic        ovrExp = 1'b0;
    logic [15:0] frameMix = '0;
    logic        snapEn [NUM_CH];
    logic [15:0] snapD  [NUM_CH];
    logic [15:0] snapS  [NUM_CH];
    logic [4:0]  snapSh [NUM_CH];
    logic [31:0] sumAll;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            age    = 0;
            mixExp = '0;
            ovrExp = 1'b0;
        end else begin
            if (sample_tick && age != 0) ovrExp = 1'b1;
            if (age == 0) begin
                if (sample_tick) begin
                    sumAll = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        snapEn[i] = ch_en[i];
                        snapD[i]  = ch_data[i*16 +: 16];
                        snapS[i]  = ch_scalar[i*16 +: 16];
                        snapSh[i] = ch_shift[i*5 +: 5];
                        if (snapEn[i]) sumAll = sumAll + {16'd0, scaleOf(snapD[i], snapS[i], snapSh[i])};
                    end
`ifdef SCALAR_SCHED_SAT_EN
                    frameMix = (sumAll > 32'hFFFF) ? 16'hFFFF : sumAll[15:0];
`else
                    frameMix = sumAll[15:0];
`endif
                    age = 1;
                end
            end else if (age == FRAME) begin
                age = 0;
            end else begin
                age = age + 1;
                if (age == FRAME) mixExp = frameMix;
            end
        end
    end

    logic [15:0] expD, expS;
    logic [4:0]  expSh;

    always @(negedge clk) begin
        expD = '0;
        expS = '0;
        expSh = '0;
        if (age >= 1 && age <= NUM_CH) begin
            if (snapEn[age-1]) begin
                expD  = snapD[age-1];
                expS  = snapS[age-1];
                expSh = snapSh[age-1];
            end
        end
        checkOutput("sc_data_in", 32'(sc_data_in), 32'(expD));
        checkOutput("sc_scalar", 32'(sc_scalar), 32'(expS));
        checkOutput("sc_shift", 32'(sc_shift), 32'(expSh));
        checkOutput("busy", 32'(busy), 32'(age != 0));
        checkOutput("mix_valid", 32'(mix_valid), 32'(age == FRAME));
        checkOutput("mix_out", 32'(mix_out), 32'(mixExp));
        checkOutput("overrun", 32'(overrun), 32'(ovrExp));
    end

    task automatic randomizeInputs();
        logic [31:0] r;
        r = $urandom;
        ch_en     = r[NUM_CH-1:0];
        ch_data   = {$urandom(), $urandom()};
        ch_scalar = {$urandom(), $urandom()};
        r = $urandom;
        ch_shift  = r[NUM_CH*5-1:0];
    endtask

    task automatic setUniform(input logic [3:0] en, input logic [15:0] d, input logic [15:0] s, input logic [4:0] sh);
        ch_en     = en;
        ch_data   = {NUM_CH{d}};
        ch_scalar = {NUM_CH{s}};
        ch_shift  = {NUM_CH{sh}};
    endtask

    task automatic pulseTick();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [15:0] d, input logic [15:0] s,
                                 input logic [4:0] sh, input logic [15:0] expMix);
        int lat;
        int busyCycles;
        setUniform(en, d, s, sh);
        pulseTick();
        randomizeInputs();
        lat = 0;
        busyCycles = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busyCycles++;
            if (mix_valid) break;
        end
        if (lat >= 20) checkOutput("mix_valid_timeout", 32'(0), 32'(1));
        checkOutput("latency", 32'(lat), 32'(7));
        checkOutput("busy_cycles", 32'(busyCycles), 32'(7));
        checkOutput("frame_mix", 32'(mix_out), 32'(expMix));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int mv;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        checkOutput("rst_mix_out", 32'(mix_out), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_overrun", 32'(overrun), 32'(0));
        checkOutput("rst_sc_data_in", 32'(sc_data_in), 32'(0));

        applyStimulus(4'b0000, 16'h1234, 16'h5678, 5'd3, 16'h0000);
        applyStimulus(4'b0001, 16'h0001, 16'h0008, 5'd0, 16'h0008);
        applyStimulus(4'b1111, 16'h0FFF, 16'h0010, 5'd4, 16'h3FFC);
`ifdef SCALAR_SCHED_SAT_EN
        applyStimulus(4'b1111, 16'hFFFF, 16'h0001, 5'd0, 16'hFFFF);
`else
        applyStimulus(4'b1111, 16'hFFFF, 16'h0001, 5'd0, 16'hFFFC);
`endif

        // Second tick three cycles into a frame
        setUniform(4'b1111, 16'h0FFF, 16'h0010, 5'd4);
        pulseTick();
        repeat (2) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        mv = 0;
        repeat (12) begin
            @(negedge clk);
            if (mix_valid) begin
                mv++;
                checkOutput("ovr_mix_out", 32'(mix_out), 32'(16'h3FFC));
            end
        end
        checkOutput("ovr_valid_count", 32'(mv), 32'(1));
        checkOutput("ovr_flag", 32'(overrun), 32'(1));
        applyStimulus(4'b0001, 16'h0001, 16'h0008, 5'd0, 16'h0008);
        checkOutput("ovr_sticky", 32'(overrun), 32'(1));

        // Reset in the middle of a frame
        setUniform(4'b1111, 16'h0100, 16'h0002, 5'd1);
        pulseTick();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'(0));
        checkOutput("midrst_mix_out", 32'(mix_out), 32'(0));
        checkOutput("midrst_overrun", 32'(overrun), 32'(0));
        checkOutput("midrst_sc_data_in", 32'(sc_data_in), 32'(0));
        checkOutput("midrst_mix_valid", 32'(mix_valid), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mv = 0;
        repeat (10) begin
            @(negedge clk);
            if (mix_valid) mv++;
        end
        checkOutput("midrst_no_valid", 32'(mv), 32'(0));
        applyStimulus(4'b1111, 16'h0100, 16'h0002, 5'd1, 16'h0400);

        repeat (1500) begin
            @(posedge clk);
            #1;
            randomizeInputs();
            sample_tick = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 199) != 0);
        end
        #1;
        sample_tick = 1'b0;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
